booth_mult_r4: RTL

Parametrised, sequential radix-4 Booth multiplier. It is the successor to the team's fixed 4-bit radix-2 signed Booth multiplier. It adds a generic operand width, a per-operation signed/unsigned mode, busy status, and an explicit one-cycle done pulse. It sits in the arithmetic datapath as a multi-cycle multiply unit driven by a start/done handshake.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_r4_encoder.sv | 21 ++
 rtl/booth_mult_r4.sv | 122 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// The FSM states, the recoded Booth digits and the iteration count for a given operand width.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    DIG_0,
    DIG_P1,
    DIG_P2,
    DIG_M1,
    DIG_M2
  } digit_t;

  // Radix-4 steps needed for a WIDTH operand extended by two bits
  function automatic int iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder.
// Maps the 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} to a signed digit.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output digit_t     digit
);

  always_comb begin
    digit = DIG_0;
    case (window)
      3'b001, 3'b010: digit = DIG_P1;
      3'b011:         digit = DIG_P2;
      3'b100:         digit = DIG_M2;
      3'b101, 3'b110: digit = DIG_M1;
      default:        digit = DIG_0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with signed/unsigned mode and a start/done handshake.
// The multiplier shifts right out of the low half while partial products accumulate in the high half.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int W2 = WIDTH + 2;
  localparam int N  = iters(WIDTH);
  localparam int CW = $clog2(N + 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_r4: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [W2-1:0]         a_reg;
  logic [W2+1:0]         hi_reg;
  logic [W2-1:0]         lo_reg;
  logic                  bm1_reg;
  logic [CW-1:0]         cnt_reg;
  logic [2*WIDTH-1:0]    product_reg;

  digit_t                digit;
  logic [W2+1:0]         a_ext;
  logic [W2+1:0]         pp;
  logic [W2+1:0]         sum;
  logic signed [2*W2+1:0] full;
  logic signed [2*W2+1:0] shifted;
  logic [W2-1:0]         a_ld, b_ld;
  logic                  load;
  logic                  last_step;

  booth_r4_encoder u_enc (
    .window ({lo_reg[1:0], bm1_reg}),
    .digit  (digit)
  );

  // Extension width is fixed at two bits so that +/-2a always fits the accumulator
  assign a_ld = tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ld = tc ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  assign load      = start && (state_reg != CALC);
  assign last_step = (state_reg == CALC) && (cnt_reg == CW'(N - 1));

  always_comb begin
    a_ext = {{2{a_reg[W2-1]}}, a_reg};
    pp    = '0;
    case (digit)
      DIG_P1:  pp = a_ext;
      DIG_P2:  pp = a_ext << 1;
      DIG_M1:  pp = (W2+2)'(0) - a_ext;
      DIG_M2:  pp = (W2+2)'(0) - (a_ext << 1);
      default: pp = '0;
    endcase
    sum     = hi_reg + pp;
    full    = {sum, lo_reg};
    shifted = full >>> 2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      bm1_reg     <= 1'b0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (load) begin
      a_reg   <= a_ld;
      hi_reg  <= '0;
      lo_reg  <= b_ld;
      bm1_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (state_reg == CALC) begin
      hi_reg  <= shifted[2*W2+1:W2];
      lo_reg  <= shifted[W2-1:0];
      bm1_reg <= lo_reg[1];
      cnt_reg <= cnt_reg + CW'(1);
      // Capture on the final step so product is already valid during the done cycle
      if (last_step) begin
        product_reg <= shifted[2*WIDTH-1:0];
      end
    end
  end

  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule
